// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the serial adder/subtractor: start request, operands, busy/done status, result.
// master drives the request side; slave is the arithmetic block.
interface serial_add_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract, DIGIT bits per cycle LSB first; done pulses N+1 edges after an accepted start.
// No backpressure: start is honoured only in IDLE, ignored (not queued) while busy or in the done cycle.
module serial_add_sub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   serial_add_sub_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [DIGIT-1:0] d_sum;
   logic [DIGIT:0]   c;
   logic [WIDTH-1:0] res_next;

   // Ripple chain of full adders over the current low digit; c[DIGIT-1] is
   // the carry into the top bit, needed for overflow on the last digit.
   always_comb begin
      c     = '0;
      d_sum = '0;
      c[0]  = carry;
      for (int i = 0; i < DIGIT; i++) begin
         d_sum[i] = a_sh[i] ^ b_sh[i] ^ c[i];
         c[i+1]   = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
      end
   end

   assign res_next = WIDTH'({d_sum, res_sh} >> DIGIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
         bus.ovf  <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  // Subtract is A + ~B + 1, so the operation kind is folded
                  // into B' and the initial carry here.
                  a_sh     <= bus.a;
                  b_sh     <= bus.b ^ {WIDTH{bus.sub}};
                  carry    <= bus.sub | bus.cin;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               carry  <= c[DIGIT];
               a_sh   <= a_sh >> DIGIT;
               b_sh   <= b_sh >> DIGIT;
               res_sh <= res_next;
               if (cnt == LAST) begin
                  bus.sum  <= res_next;
                  bus.cout <= c[DIGIT];
                  bus.ovf  <= c[DIGIT] ^ c[DIGIT-1];
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and randomised checks of serial_add_sub at DIGIT=1 and DIGIT=4 against an arithmetic model.
module tb_serial_add_sub;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;

   serial_add_sub_if #(.WIDTH(8)) if8 ();
   serial_add_sub_if #(.WIDTH(8)) if4 ();

   serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   serial_add_sub #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {busy, done, cout, ovf, sum}
   function automatic logic [11:0] pk(input bit d4);
      return d4 ? {if4.busy, if4.done, if4.cout, if4.ovf, if4.sum}
                : {if8.busy, if8.done, if8.cout, if8.ovf, if8.sum};
   endfunction

   task automatic drive(input bit d4, input logic st, input logic [7:0] a, input logic [7:0] b,
                        input logic sb, input logic ci);
      if (d4) begin
         if4.start = st; if4.a = a; if4.b = b; if4.sub = sb; if4.cin = ci;
      end else begin
         if8.start = st; if8.a = a; if8.b = b; if8.sub = sb; if8.cin = ci;
      end
   endtask

   task automatic drive_rnd(input bit d4, input logic st);
      drive(d4, st, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // Plain integer arithmetic: sum modulo 256, carry/no-borrow, signed range overflow.
   task automatic model(input logic [7:0] a, input logic [7:0] b, input logic sb, input logic ci,
                        output logic [7:0] s, output logic c, output logic o);
      int ua, ub, sa, sbv, r;
      ua  = int'(a);
      ub  = int'(b);
      sa  = (ua > 127) ? ua - 256 : ua;
      sbv = (ub > 127) ? ub - 256 : ub;
      if (sb) begin
         s = 8'(ua - ub);
         c = (ua >= ub);
         r = sa - sbv;
      end else begin
         s = 8'(ua + ub + int'(ci));
         c = (ua + ub + int'(ci)) > 255;
         r = sa + sbv + int'(ci);
      end
      o = (r > 127) || (r < -128);
   endtask

   task automatic run_op(input string tag, input bit d4, input logic [7:0] a, input logic [7:0] b,
                         input logic sb, input logic ci, input int disturb);
      int n, lat, busy_n, extra;
      bit got;
      logic busy_at_done;
      logic [11:0] o;
      logic [7:0] es;
      logic ec, eo;
      n = d4 ? 2 : 8;
      model(a, b, sb, ci, es, ec, eo);
      @(negedge clk);
      drive(d4, 1'b1, a, b, sb, ci);
      lat = 0; busy_n = 0; got = 0; busy_at_done = 1'b1;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         o = pk(d4);
         if (o[10]) begin
            got = 1; lat = i; busy_at_done = o[11];
         end else if (o[11]) begin
            busy_n++;
         end
         // Operands are scrambled after accept; they must not affect the result.
         drive_rnd(d4, (i == disturb) ? 1'b1 : 1'b0);
      end
      chk({tag, " done_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(lat), 32'(n + 1));
      chk({tag, " busy_cycles"}, 32'(busy_n), 32'(n));
      chk({tag, " busy_at_done"}, 32'(busy_at_done), 32'd0);
      o = pk(d4);
      chk({tag, " sum"}, 32'(o[7:0]), 32'(es));
      chk({tag, " cout"}, 32'(o[9]), 32'(ec));
      chk({tag, " ovf"}, 32'(o[8]), 32'(eo));
      extra = 0;
      for (int i = 0; i < n + 3; i++) begin
         @(negedge clk);
         if (pk(d4) >> 10 & 12'd1) extra++;
      end
      chk({tag, " extra_done"}, 32'(extra), 32'd0);
      o = pk(d4);
      chk({tag, " sum_held"}, 32'(o[7:0]), 32'(es));
   endtask

   initial begin
      logic [11:0] o;
      int t[3];
      int cnt, extra;
      logic [7:0] ra, rb;
      logic rs, rc;

      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state_d1", 32'(pk(1'b0)), 32'd0);
      chk("reset_state_d4", 32'(pk(1'b1)), 32'd0);
      rst_n = 1'b1;

      run_op("t1", 1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
      chk("t1_const", 32'(pk(1'b0)), 32'({1'b0, 1'b0, 1'b0, 1'b1, 8'h80}));
      run_op("t2a", 1'b0, 8'hFF, 8'h01, 1'b0, 1'b1, 0);
      chk("t2a_const", 32'(pk(1'b0)), 32'({1'b0, 1'b0, 1'b1, 1'b0, 8'h01}));
      run_op("t2b", 1'b0, 8'h05, 8'h07, 1'b1, 1'b0, 0);
      chk("t2b_const", 32'(pk(1'b0)), 32'({1'b0, 1'b0, 1'b0, 1'b0, 8'hFE}));
      run_op("t3", 1'b0, 8'h80, 8'h01, 1'b1, 1'b0, 0);

      @(negedge clk);
      drive(1'b0, 1'b0, 8'hAA, 8'h55, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      chk("t3_idle_hold", 32'(pk(1'b0)), 32'({1'b0, 1'b0, 1'b1, 1'b1, 8'h7F}));

      run_op("t4_disturb", 1'b0, 8'h5A, 8'h33, 1'b0, 1'b1, 3);

      // Abort in the fourth busy cycle.
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("t5_busy_before_rst", 32'(if8.busy), 32'd1);
      #1 rst_n = 1'b0;
      #1 chk("t5_outputs_in_rst", 32'(pk(1'b0)), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (if8.done) extra++;
      end
      chk("t5_no_done_after_abort", 32'(extra), 32'd0);
      run_op("t5_fresh", 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 0);

      run_op("t6", 1'b1, 8'h3C, 8'h4B, 1'b0, 1'b1, 0);
      chk("t6_const", 32'(pk(1'b1)), 32'({1'b0, 1'b0, 1'b0, 1'b1, 8'h88}));
      run_op("t6_sub", 1'b1, 8'h10, 8'h20, 1'b1, 1'b1, 0);

      // start held high: one result every N+2 cycles.
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h21, 8'h13, 1'b0, 1'b0);
      cnt = 0;
      for (int i = 0; i < 60 && cnt < 3; i++) begin
         @(negedge clk);
         if (if8.done) begin
            t[cnt] = cyc;
            cnt++;
         end
      end
      drive(1'b0, 1'b0, 8'h21, 8'h13, 1'b0, 1'b0);
      chk("held_done_count", 32'(cnt), 32'd3);
      chk("held_period_1", 32'(t[1] - t[0]), 32'd10);
      chk("held_period_2", 32'(t[2] - t[1]), 32'd10);
      o = pk(1'b0);
      chk("held_sum", 32'(o[7:0]), 32'h34);
      repeat (4) @(negedge clk);

      for (int k = 0; k < 1000; k++) begin
         ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
         run_op("rnd_d1", 1'b0, ra, rb, rs, rc, ((k % 7) == 0) ? 3 : 0);
      end
      for (int k = 0; k < 200; k++) begin
         ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
         run_op("rnd_d4", 1'b1, ra, rb, rs, rc, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
